// File: rtl/waveform_capture_to_pipe_pkg.sv
// waveform_capture_to_pipe_pkg: state encoding, default depth and halfword order for waveform capture.
package waveform_capture_to_pipe_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_ARMED   = 3'd1;
  localparam state_t S_CAPTURE = 3'd2;
  localparam state_t S_FLUSH   = 3'd3;
  localparam state_t S_DONE    = 3'd4;
  // Must equal the playback block's depth so a record can be replayed as-is.
  localparam int WAVE_ADDR_W = 11;
  localparam logic HALF_LO_FIRST = 1'b1;
endpackage

// File: rtl/waveform_capture_to_pipe_ram.sv
// wave_capture_ram: single-port DEPTH x 32 synchronous block RAM, 1-cycle read latency.
module wave_capture_ram
  import waveform_capture_to_pipe_pkg::*;
#(
  parameter int ADDR_W = WAVE_ADDR_W
)(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout
);
  logic [31:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/waveform_capture_to_pipe.sv
// waveform_capture_to_pipe: arm/trigger capture of a 32-bit bus into RAM, read back as 16-bit halfwords.
// Optional strobe decimation when WAVE_CAPTURE_DECIM_EN is defined.
module waveform_capture_to_pipe
  import waveform_capture_to_pipe_pkg::*;
#(
  parameter int ADDR_W = WAVE_ADDR_W
`ifdef WAVE_CAPTURE_DECIM_EN
  , parameter int DECIM_W = 8
`endif
)(
  input  logic               pipe_clk,
  input  logic               reset_n,
  input  logic               arm,
  input  logic               trigger,
  input  logic               sample_strobe,
  input  logic [31:0]        sample_in,
`ifdef WAVE_CAPTURE_DECIM_EN
  input  logic [DECIM_W-1:0] decim,
`endif
  input  logic               pipe_out_read,
  output logic [15:0]        pipe_out_data,
  output logic               capturing,
  output logic               capture_done,
  output logic [ADDR_W:0]    sample_count
);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     sample_count_q, sample_count_d;
  logic [ADDR_W:0]     rd_hptr_q, rd_hptr_d;
  logic [31:0]         cur_word_q, cur_word_d;
  logic                first_q, first_d;
  logic                keep, ram_we, hi;
  logic [ADDR_W-1:0]   ram_addr;
  logic [31:0]         ram_dout, cur;
`ifdef WAVE_CAPTURE_DECIM_EN
  logic [DECIM_W-1:0]  dcnt_q, dcnt_d;
  assign keep = state_q == S_CAPTURE && sample_strobe && dcnt_q == '0;
`else
  assign keep = state_q == S_CAPTURE && sample_strobe;
`endif
  // In DONE the address always points one word ahead; the RAM output register doubles as the next-word holder.
  assign ram_addr = state_q == S_CAPTURE ? wr_ptr_q
                  : state_q == S_FLUSH   ? '0
                  : rd_hptr_q[ADDR_W:1] + 1'b1;
  assign cur = first_q ? ram_dout : cur_word_q;
  assign hi  = rd_hptr_q[0] == HALF_LO_FIRST;
  assign pipe_out_data = state_q == S_DONE ? (hi ? cur[31:16] : cur[15:0]) : 16'h0000;
  assign capturing     = state_q == S_CAPTURE;
  assign capture_done  = state_q == S_DONE;
  assign sample_count  = sample_count_q;
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    sample_count_d = sample_count_q;
    rd_hptr_d      = rd_hptr_q;
    cur_word_d     = cur_word_q;
    first_d        = 1'b0;
    ram_we         = 1'b0;
`ifdef WAVE_CAPTURE_DECIM_EN
    dcnt_d         = dcnt_q;
`endif
    case (state_q)
      S_IDLE:  if (arm) state_d = S_ARMED;
      S_ARMED: if (trigger) begin
        state_d = S_CAPTURE;
`ifdef WAVE_CAPTURE_DECIM_EN
        dcnt_d  = '0;
`endif
      end
      S_CAPTURE: begin
`ifdef WAVE_CAPTURE_DECIM_EN
        if (sample_strobe) dcnt_d = keep ? decim : dcnt_q - 1'b1;
`endif
        if (keep) begin
          ram_we         = 1'b1;
          wr_ptr_d       = wr_ptr_q + 1'b1;
          sample_count_d = sample_count_q[ADDR_W] ? sample_count_q : sample_count_q + 1'b1;
          if (&wr_ptr_q) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        rd_hptr_d = '0;
        first_d   = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        cur_word_d = cur;
        if (pipe_out_read) begin
          rd_hptr_d = rd_hptr_q + 1'b1;
          if (rd_hptr_q[0]) cur_word_d = ram_dout;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (arm && state_q != S_IDLE) begin
      state_d        = S_ARMED;
      wr_ptr_d       = '0;
      sample_count_d = '0;
      rd_hptr_d      = '0;
      first_d        = 1'b0;
      ram_we         = 1'b0;
`ifdef WAVE_CAPTURE_DECIM_EN
      dcnt_d         = '0;
`endif
    end
  end
  always_ff @(posedge pipe_clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      sample_count_q <= '0;
      rd_hptr_q      <= '0;
      cur_word_q     <= '0;
      first_q        <= 1'b0;
`ifdef WAVE_CAPTURE_DECIM_EN
      dcnt_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      sample_count_q <= sample_count_d;
      rd_hptr_q      <= rd_hptr_d;
      cur_word_q     <= cur_word_d;
      first_q        <= first_d;
`ifdef WAVE_CAPTURE_DECIM_EN
      dcnt_q         <= dcnt_d;
`endif
    end
  end
  wave_capture_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk  (pipe_clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (sample_in),
    .dout (ram_dout)
  );
endmodule

// File: doc/waveform_capture_to_pipe.md
# waveform_capture_to_pipe

Records a 32-bit waveform into block RAM and returns it to the host over a 16-bit pipe-out. It is the return path for the waveform playback block: playback pops host-supplied samples onto a `wave` bus, and this block captures a `wave`-style bus on a sample strobe after an arm/trigger sequence. The host then drains the record as 16-bit halfwords, low half first. Everything runs on the pipe clock, and sample strobes arrive already synchronised to it.

## Interface
Parameters:
- ADDR_W, 11: word address width; capture depth DEPTH = 2**ADDR_W 32-bit words.
- DECIM_W, 8: width of decimation control (used only with WAVE_CAPTURE_DECIM_EN).

Ports:
- pipe_clk  in  1  single clock for all logic and RAM.
- reset_n  in  1  synchronous, active-low reset.
- arm  in  1  one-cycle pulse; (re)starts a capture sequence.
- trigger  in  1  level/pulse; starts capture while ARMED.
- sample_strobe  in  1  one-cycle pulse per sample period.
- sample_in  in  32  sample captured on sample_strobe.
- decim  in  DECIM_W  keep one of every decim+1 strobes (macro only).
- pipe_out_read  in  1  host read strobe, one halfword per asserted cycle.
- pipe_out_data  out  16  current halfword.
- capturing  out  1  high in CAPTURE.
- capture_done  out  1  high in DONE.
- sample_count  out  ADDR_W+1  words written this capture.

## Operation
- States: IDLE, ARMED, CAPTURE, FLUSH, DONE.
- IDLE -> ARMED on arm.
- ARMED -> CAPTURE on trigger. A trigger in the same cycle as arm is ignored, so capture needs a trigger at least one cycle after arm.
- CAPTURE: each accepted strobe writes sample_in to mem[wr_ptr], then increments wr_ptr and sample_count. After word DEPTH-1 is written -> FLUSH. sample_count saturates at DEPTH.
- FLUSH: rd_hptr=0 and a RAM read of word 0 is issued. Stays one cycle, then goes to DONE.
- DONE: pipe_out_data is halfword rd_hptr. Halfword 2k is word k [15:0]; halfword 2k+1 is word k [31:16].
  - Each pipe_out_read cycle advances rd_hptr by 1.
  - After halfword 2*DEPTH-1, rd_hptr wraps to 0.
- arm in any state except IDLE aborts the current sequence. The block clears wr_ptr, sample_count and rd_hptr, then goes to ARMED. Previously captured RAM contents are not cleared.
- pipe_out_read outside DONE is ignored: pointer unchanged, pipe_out_data = 16'h0000.
- sample_strobe outside CAPTURE is ignored.
- arm and sample_strobe in the same CAPTURE cycle: abort wins and no write occurs.
- RAM is accessed only by the write port in CAPTURE and the read port in FLUSH/DONE, so one address mux is enough and there are no collisions.

## Timing
- Reset (reset_n=0 at a clock edge) returns to IDLE, mid-capture or mid-readout alike. Reset values:
  - pipe_out_data = 0
  - capturing = 0, capture_done = 0, sample_count = 0
  - pointers = 0, decimation counter = 0
- RAM read latency is 1 cycle and write latency is 1 cycle.
- The first accepted strobe is the first one in the cycle after entering CAPTURE. capturing rises the cycle after the trigger.
- sample_count updates the cycle after each accepted strobe.
- capture_done rises 2 cycles after the final write (CAPTURE -> FLUSH -> DONE). At that point word 0 is already loaded and pipe_out_data = mem[0][15:0].
- pipe_out_data changes to the next halfword the cycle after a pipe_out_read cycle. Back-to-back reads every cycle must be sustained.
  - This requires prefetch: while on the low half of word k, issue a read of word k+1 (mod DEPTH).
  - Hold the fetched word in a next-word register, and swap it in on the high->low transition.

## Configuration
- WAVE_CAPTURE_DECIM_EN defined:
  - The decim port exists, and a DECIM_W-bit strobe counter runs in CAPTURE.
  - The first strobe is kept, then the next decim strobes are skipped. decim=0 keeps every strobe.
  - The counter clears on entering CAPTURE.
  - decim is sampled on every strobe; changing it mid-capture takes effect at the next kept strobe.
- Undefined: there is no decim port and every strobe in CAPTURE is kept.

## Structure
- The shared package holds:
  - the state encoding typedef (IDLE/ARMED/CAPTURE/FLUSH/DONE);
  - the default ADDR_W constant, which must match the playback block's depth so a recorded waveform can be replayed;
  - the halfword-order constant (low half first).
- One sub-module, wave_capture_ram: single-port DEPTH x 32 synchronous RAM with we, addr, din, dout and 1-cycle read latency. Infer it as block RAM.

## Test plan
- Arm, trigger, then 2048 strobes with sample_in = 32'hA5000000 + i:
  - capture_done rises 2 cycles after the last write and sample_count = 2048.
  - Reading halfwords back-to-back returns 0000, A500, 0001, A500, …
- Full readout of 4096 halfwords, then 2 more reads: the data wraps to 0000, A500.
- Abort with arm after 100 samples, then trigger and capture 2048 samples of 32'h11110000 + i:
  - sample_count resets to 0 on the abort.
  - The final record starts at word 0 = 32'h11110000.
- Robustness cases:
  - trigger in the same cycle as arm: stays ARMED and capturing = 0.
  - pipe_out_read during CAPTURE: pipe_out_data = 0000 and the readout pointer later starts at 0.
- Reset asserted mid-readout at halfword 37: all outputs reach their reset values next cycle, and the state is IDLE.
- With WAVE_CAPTURE_DECIM_EN and decim=3, 8192 strobes are needed to fill the record. Word k equals strobe index 4k.
